l2cache_req_arbiter: RTL
========================

# l2cache_req_arbiter

Arbitrates the single L2 request buffer between three requesters: the I-cache read port, the D-cache read/write/cacop port, and the L2 prefetcher. It selects one requester, drives the buffer write strobe and all buffered request fields, grants the winner, then blocks new requests until the L2 main pipeline signals completion. It sits directly in front of the L2 request buffer and replaces any ad-hoc muxing in the L2 top.

## Interface
- PF_ENABLE, 1: 0 = prefetch port never granted, pf_gnt tied 0
- STARVE_LIMIT, 4: consecutive demand grants with pf_req pending before prefetch is forced; range 1..15
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- i_req  in  1  I-cache read request, held until i_gnt
- i_addr  in  32  I-cache address; i_suc in 1 uncached; i_size in 2 access size
- d_req  in  1  D-cache request, held until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr, d_data  in  32  D address / write data; d_wstrb in 4; d_size in 2; d_suc in 1
- d_opflag  in  1  cache-op flag; d_opcode, d_opaddr in 32 cache-op code/address
- pf_req  in  1  prefetch request; pf_addr in 32; pf_type in 1
- l2_done  in  1  one-cycle pulse: L2 finished current buffered request
- i_gnt, d_gnt, pf_gnt  out  1  one-cycle grant pulses
- rbuf_we  out  1  write strobe to request buffer
- addr, data, opcode, opaddr  out  32  buffered fields
- opflag, SUC, prefetch, pref_type  out  1  buffered flags
- wstrb  out  4; from out 2 (0 none, 1 I, 2 D read, 3 D write); size out 2
- busy  out  1  request outstanding in L2

## Operation
- States: IDLE, BUSY. Registers: state, last_demand (0 = I, 1 = D), starve_cnt (4 bits).
- IDLE, eligible request present: rbuf_we = 1, matching gnt = 1, fields driven from winner (combinational); next state BUSY.
- Selection, in order:
  - pf_req && PF_ENABLE && starve_cnt == STARVE_LIMIT -> prefetch.
  - i_req && d_req -> requester opposite last_demand.
  - single demand -> that requester.
  - else pf_req && PF_ENABLE -> prefetch.
- last_demand updates to the granted demand port; unchanged on prefetch grant.
- starve_cnt:
  - +1, saturating at STARVE_LIMIT, on a demand grant while pf_req = 1.
  - cleared on pf grant or whenever pf_req = 0.
- Field mapping:
  - I: addr = i_addr, SUC = i_suc, size = i_size, from = 1.
  - D: addr/data/wstrb/size/SUC/opflag/opcode/opaddr from d_*; from = 3 if d_we else 2.
  - Prefetch: addr = pf_addr, prefetch = 1, pref_type = pf_type, size = 2, from = 0.
  - All unlisted fields are 0.
- When rbuf_we = 0, all field outputs are 0.
- BUSY: no grants, rbuf_we = 0, busy = 1. l2_done -> IDLE next cycle.
- l2_done in IDLE is ignored.

## Timing
- Reset:
  - state = IDLE, last_demand = 0, starve_cnt = 0.
  - All outputs 0 while rstn = 0: rbuf_we, gnts and busy gated.
- Grant latency: 0 cycles. A request visible in IDLE is granted in the same cycle, and the buffer captures on that edge.
- busy rises the cycle after the grant.
- Minimum spacing between grants: grant, ≥1 BUSY cycle, l2_done, IDLE. With l2_done in the first BUSY cycle, the next grant occurs 2 cycles after the previous one.
- No grant in the l2_done cycle; a new request is granted on the following (IDLE) cycle.
- Requests dropped before grant are not remembered. Losers must hold req.
- Reset asserted in BUSY: returns to IDLE without l2_done; no grant in the reset cycle.

## Test plan
- i_req = 1, addr 0x1000 in IDLE after reset -> same cycle: rbuf_we = 1, i_gnt = 1, from = 1, addr = 0x1000; busy = 1 next cycle; no grant until l2_done.
- i_req and d_req both held, d_we = 1, wstrb 0xF, l2_done two cycles after each grant -> grant order D, I, D, I; from = 3, 1, 3, 1.
- pf_req held with demand requests held, STARVE_LIMIT = 4 -> four demand grants, then pf_gnt with prefetch = 1, from = 0; starve_cnt returns to 0.
- PF_ENABLE = 0, only pf_req held for 20 cycles -> no rbuf_we, pf_gnt stays 0.
- Grant, then rstn = 0 one cycle in BUSY -> busy = 0, state IDLE; held d_req granted first cycle after reset release (last_demand reset to 0, so D wins).
- d_req with d_opflag = 1, opcode 0x9, opaddr 0x2040 -> opflag = 1, opcode = 0x9, opaddr = 0x2040 with rbuf_we; all fields 0 in the following BUSY cycle.

Source files
------------

// File: rtl/l2cache_req_arbiter.sv
// l2cache_req_arbiter: picks one of the I-cache, D-cache and prefetch requesters
// for the single L2 request buffer. The winner is granted in the same cycle,
// then new requests are blocked until the L2 pipeline pulses l2_done.
module l2cache_req_arbiter #(
  parameter bit          PF_ENABLE    = 1'b1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_suc,
  input  logic [1:0]  i_size,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_data,
  input  logic [3:0]  d_wstrb,
  input  logic [1:0]  d_size,
  input  logic        d_suc,
  input  logic        d_opflag,
  input  logic [31:0] d_opcode,
  input  logic [31:0] d_opaddr,
  input  logic        pf_req,
  input  logic [31:0] pf_addr,
  input  logic        pf_type,
  input  logic        l2_done,
  output logic        i_gnt,
  output logic        d_gnt,
  output logic        pf_gnt,
  output logic        rbuf_we,
  output logic [31:0] addr,
  output logic [31:0] data,
  output logic [31:0] opcode,
  output logic [31:0] opaddr,
  output logic        opflag,
  output logic        SUC,
  output logic        prefetch,
  output logic        pref_type,
  output logic [3:0]  wstrb,
  output logic [1:0]  from,
  output logic [1:0]  size,
  output logic        busy
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_q, state_d;
  logic       last_demand_q, last_demand_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;

  logic pf_ok;
  logic sel_i, sel_d, sel_pf;

  // Winner selection: starvation-forced prefetch, then demand round-robin, then idle prefetch.
  always_comb begin
    sel_i  = 1'b0;
    sel_d  = 1'b0;
    sel_pf = 1'b0;
    pf_ok  = pf_req && PF_ENABLE;
    if (rstn && state_q == IDLE) begin
      if (pf_ok && starve_cnt_q == STARVE_MAX) begin
        sel_pf = 1'b1;
      end else if (i_req && d_req) begin
        sel_i = last_demand_q;
        sel_d = !last_demand_q;
      end else if (i_req) begin
        sel_i = 1'b1;
      end else if (d_req) begin
        sel_d = 1'b1;
      end else if (pf_ok) begin
        sel_pf = 1'b1;
      end
    end
  end

  // Grant pulses and buffered fields; every field stays 0 unless a grant is being written.
  always_comb begin
    i_gnt     = sel_i;
    d_gnt     = sel_d;
    pf_gnt    = sel_pf;
    rbuf_we   = sel_i || sel_d || sel_pf;
    busy      = rstn && (state_q == BUSY);
    addr      = '0;
    data      = '0;
    opcode    = '0;
    opaddr    = '0;
    opflag    = 1'b0;
    SUC       = 1'b0;
    prefetch  = 1'b0;
    pref_type = 1'b0;
    wstrb     = '0;
    from      = 2'd0;
    size      = 2'd0;
    if (sel_i) begin
      addr = i_addr;
      SUC  = i_suc;
      size = i_size;
      from = 2'd1;
    end else if (sel_d) begin
      addr   = d_addr;
      data   = d_data;
      wstrb  = d_wstrb;
      size   = d_size;
      SUC    = d_suc;
      opflag = d_opflag;
      opcode = d_opcode;
      opaddr = d_opaddr;
      from   = d_we ? 2'd3 : 2'd2;
    end else if (sel_pf) begin
      addr      = pf_addr;
      prefetch  = 1'b1;
      pref_type = pf_type;
      size      = 2'd2;
    end
  end

  // Next-state for the FSM, round-robin pointer and prefetch starvation counter.
  always_comb begin
    state_d       = state_q;
    last_demand_d = last_demand_q;
    starve_cnt_d  = starve_cnt_q;
    case (state_q)
      IDLE: if (rbuf_we) state_d = BUSY;
      BUSY: if (l2_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (sel_i) last_demand_d = 1'b0;
    if (sel_d) last_demand_d = 1'b1;
    if (!pf_req || sel_pf) begin
      starve_cnt_d = '0;
    end else if ((sel_i || sel_d) && starve_cnt_q != STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      last_demand_q <= 1'b0;
      starve_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      last_demand_q <= last_demand_d;
      starve_cnt_q  <= starve_cnt_d;
    end
  end

endmodule
